// File: rtl/dfr_phase_sequencer.sv
// -----------------------------------------------------------------------------
// dfr_phase_sequencer
//   Run sequencer for the DFR core. A run streams input-memory samples through
//   the reservoir in two phases:
//     INIT (warm-up, outputs discarded) then RUN (outputs written to history).
//   Afterwards it optionally launches the matrix multiplier and reports done.
//   Step counts come from registers at runtime; all config is latched at start.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             begin a run (only accepted in IDLE)
//   abort             cancel the current run (ignored in IDLE)
//   skip_mm           1: skip the matrix-multiply phase
//   num_init_steps    warm-up step count (CNT_WIDTH)
//   num_run_steps     recorded step count (ADDR_WIDTH), must be non-zero
//   mm_busy           matrix multiplier busy
//   busy              high in every state except IDLE
//   done              1-cycle pulse on successful completion
//   err               1-cycle pulse when a start is rejected (run count 0)
//   phase             encoded state (IDLE=0 .. DONE=7)
//   input_addr        input RAM read address (RAM has 1-cycle read latency)
//   reservoir_en      reservoir step enable
//   reservoir_rst     reservoir clear
//   history_wen       history RAM write enable
//   history_addr      history RAM write address
//   mm_start          1-cycle matrix-multiply start pulse
// -----------------------------------------------------------------------------
module dfr_phase_sequencer #(
    parameter int ADDR_WIDTH  = 16,
    parameter int CNT_WIDTH   = 32,
    parameter int RES_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  skip_mm,
    input  logic [CNT_WIDTH-1:0]  num_init_steps,
    input  logic [ADDR_WIDTH-1:0] num_run_steps,
    input  logic                  mm_busy,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            phase,
    output logic [ADDR_WIDTH-1:0] input_addr,
    output logic                  reservoir_en,
    output logic                  reservoir_rst,
    output logic                  history_wen,
    output logic [ADDR_WIDTH-1:0] history_addr,
    output logic                  mm_start
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RES_RST  = 3'd1,
        S_INIT     = 3'd2,
        S_RUN      = 3'd3,
        S_DRAIN    = 3'd4,
        S_MM_START = 3'd5,
        S_MM_WAIT  = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    state_t                  r_state;
    logic [CNT_WIDTH-1:0]    r_init;
    logic [CNT_WIDTH:0]      r_total;     // init + run, one bit wider than the init count
    logic [CNT_WIDTH:0]      r_step;      // index of the step currently on input_addr
    logic                    r_skip;
    logic                    r_mm_first;  // first MM_WAIT cycle: mm_busy not yet meaningful
    logic                    r_busy;
    logic                    r_done;
    logic                    r_err;
    logic                    r_res_rst;
    logic                    r_mm_start;

    // Valid/tag pipeline: stage 0 is the reservoir_en cycle, stage RES_LATENCY the write cycle.
    logic [RES_LATENCY:0]    r_vld;
    logic [RES_LATENCY:0]    r_tag;
    logic                    r_hwen;
    logic [ADDR_WIDTH-1:0]   r_haddr;
    logic [ADDR_WIDTH-1:0]   r_hist_cnt;

    logic                    w_issue;
    logic                    w_accept;
    logic                    w_abort;
    logic                    w_wr;
    logic                    w_pending;
    logic [RES_LATENCY:0]    w_vld_in;
    logic [RES_LATENCY:0]    w_tag_in;
    logic [CNT_WIDTH:0]      w_step_next;

    assign w_issue     = ((r_state == S_INIT) || (r_state == S_RUN)) && !abort;
    assign w_abort     = (r_state != S_IDLE) && abort;
    assign w_accept    = (r_state == S_IDLE) && start && (num_run_steps != {ADDR_WIDTH{1'b0}});
    assign w_step_next = r_step + {{CNT_WIDTH{1'b0}}, 1'b1};
    assign w_wr        = w_vld_in[RES_LATENCY] & w_tag_in[RES_LATENCY];

    // Next contents of the valid/tag pipeline and whether anything is still in flight
    always_comb begin
        w_vld_in    = {(RES_LATENCY+1){1'b0}};
        w_tag_in    = {(RES_LATENCY+1){1'b0}};
        w_vld_in[0] = w_issue;
        w_tag_in[0] = (r_state == S_RUN);
        for (int i = 1; i <= RES_LATENCY; i++) begin
            w_vld_in[i] = r_vld[i-1];
            w_tag_in[i] = r_tag[i-1];
        end
        // Pending when any stage below the write stage still holds a step: the
        // top stage is written this cycle, so the pipeline is empty after it.
        w_pending = 1'b0;
        for (int i = 0; i < RES_LATENCY; i++) begin
            w_pending = w_pending | r_vld[i];
        end
    end

    // Sequencer FSM with its registered control outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_init     <= {CNT_WIDTH{1'b0}};
            r_total    <= {(CNT_WIDTH+1){1'b0}};
            r_step     <= {(CNT_WIDTH+1){1'b0}};
            r_skip     <= 1'b0;
            r_mm_first <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_res_rst  <= 1'b0;
            r_mm_start <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_res_rst  <= 1'b0;
            r_mm_start <= 1'b0;
            if (w_abort) begin
                r_state   <= S_IDLE;
                r_busy    <= 1'b0;
                r_res_rst <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_init    <= num_init_steps;
                            r_total   <= {1'b0, num_init_steps} + (CNT_WIDTH+1)'(num_run_steps);
                            r_skip    <= skip_mm;
                            r_step    <= {(CNT_WIDTH+1){1'b0}};
                            r_state   <= S_RES_RST;
                            r_busy    <= 1'b1;
                            r_res_rst <= 1'b1;
                        end else if (start) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_RES_RST: begin
                        r_state <= (r_init == {CNT_WIDTH{1'b0}}) ? S_RUN : S_INIT;
                    end
                    S_INIT: begin
                        // A run step always follows, so the index keeps counting.
                        r_step <= w_step_next;
                        if (w_step_next == {1'b0, r_init}) begin
                            r_state <= S_RUN;
                        end else begin
                            r_state <= S_INIT;
                        end
                    end
                    S_RUN: begin
                        // input_addr holds the last index once issue stops.
                        if (w_step_next == r_total) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_step <= w_step_next;
                        end
                    end
                    S_DRAIN: begin
                        if (!w_pending) begin
                            if (r_skip) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state    <= S_MM_START;
                                r_mm_start <= 1'b1;
                            end
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end
                    S_MM_START: begin
                        r_state    <= S_MM_WAIT;
                        r_mm_first <= 1'b1;
                    end
                    S_MM_WAIT: begin
                        r_mm_first <= 1'b0;
                        if (!r_mm_first && !mm_busy) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_MM_WAIT;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Step pipeline and history write address generation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld      <= {(RES_LATENCY+1){1'b0}};
            r_tag      <= {(RES_LATENCY+1){1'b0}};
            r_hwen     <= 1'b0;
            r_haddr    <= {ADDR_WIDTH{1'b0}};
            r_hist_cnt <= {ADDR_WIDTH{1'b0}};
        end else if (w_abort) begin
            // Flush: steps in flight never reach the reservoir or history RAM.
            r_vld  <= {(RES_LATENCY+1){1'b0}};
            r_tag  <= {(RES_LATENCY+1){1'b0}};
            r_hwen <= 1'b0;
        end else if (w_accept) begin
            r_vld      <= {(RES_LATENCY+1){1'b0}};
            r_tag      <= {(RES_LATENCY+1){1'b0}};
            r_hwen     <= 1'b0;
            r_haddr    <= {ADDR_WIDTH{1'b0}};
            r_hist_cnt <= {ADDR_WIDTH{1'b0}};
        end else begin
            r_vld  <= w_vld_in;
            r_tag  <= w_tag_in;
            r_hwen <= w_wr;
            if (w_wr) begin
                r_haddr    <= r_hist_cnt;
                r_hist_cnt <= r_hist_cnt + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                r_haddr <= r_haddr;
            end
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign phase         = r_state;
    assign input_addr    = r_step[ADDR_WIDTH-1:0];
    assign reservoir_en  = r_vld[0];
    assign reservoir_rst = r_res_rst;
    assign history_wen   = r_hwen;
    assign history_addr  = r_haddr;
    assign mm_start      = r_mm_start;

endmodule

// File: tb/tb_dfr_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dfr_phase_sequencer
//   Two sequencer instances: A (ADDR 16, CNT 32, latency 1) for the main
//   scenarios and B (ADDR 4, CNT 8, latency 3) for the full-address-range run.
//   A timeline model derives every output from the cycle count since start,
//   the latched config and mm_busy; it is compared against both DUTs on every
//   cycle. Directed scenarios add literal expectations on counts and timing.
// -----------------------------------------------------------------------------
module tb_dfr_phase_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_start, a_abort, a_skip, a_mmb;
    logic [31:0] a_init;
    logic [15:0] a_run;
    logic        b_start, b_abort, b_skip, b_mmb;
    logic [7:0]  b_init;
    logic [3:0]  b_run;

    logic        a_busy, a_done, a_err, a_ren, a_rrst, a_hwen, a_mmst;
    logic [2:0]  a_phase;
    logic [15:0] a_ia, a_ha;
    logic        b_busy, b_done, b_err, b_ren, b_rrst, b_hwen, b_mmst;
    logic [2:0]  b_phase;
    logic [3:0]  b_ia, b_ha;

    dfr_phase_sequencer #(.ADDR_WIDTH(16), .CNT_WIDTH(32), .RES_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .skip_mm(a_skip),
        .num_init_steps(a_init), .num_run_steps(a_run), .mm_busy(a_mmb),
        .busy(a_busy), .done(a_done), .err(a_err), .phase(a_phase),
        .input_addr(a_ia), .reservoir_en(a_ren), .reservoir_rst(a_rrst),
        .history_wen(a_hwen), .history_addr(a_ha), .mm_start(a_mmst));

    dfr_phase_sequencer #(.ADDR_WIDTH(4), .CNT_WIDTH(8), .RES_LATENCY(3)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .skip_mm(b_skip),
        .num_init_steps(b_init), .num_run_steps(b_run), .mm_busy(b_mmb),
        .busy(b_busy), .done(b_done), .err(b_err), .phase(b_phase),
        .input_addr(b_ia), .reservoir_en(b_ren), .reservoir_rst(b_rrst),
        .history_wen(b_hwen), .history_addr(b_ha), .mm_start(b_mmst));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    // ---------------- timeline model ----------------
    int lat[2]  = '{1, 3};
    int amask[2] = '{32'h0000FFFF, 32'h0000000F};
    int m_ph[2], m_k[2], m_init[2], m_run[2], m_mmw[2];
    bit m_skip[2];
    bit e_busy[2], e_done[2], e_err[2], e_ren[2], e_rrst[2], e_hwen[2], e_mmst[2];
    int e_phase[2], e_iaddr[2], e_haddr[2];

    // Phase as a function of cycles since the start cycle (start cycle is k=0)
    function automatic int tl_phase(input int k, input int ini, input int rn, input int l, input bit sk);
        int n;
        n = ini + rn;
        if (k == 1) return 1;
        if (k <= n + 1) return (k - 2 < ini) ? 2 : 3;
        if (k <= n + 2 + l) return 4;
        if (k == n + 3 + l) return sk ? 7 : 5;
        return sk ? 0 : 6;
    endfunction

    task automatic model_reset(input int d);
        m_ph[d] = 0; m_k[d] = 0; m_init[d] = 0; m_run[d] = 0; m_mmw[d] = 0; m_skip[d] = 1'b0;
        e_busy[d] = 1'b0; e_done[d] = 1'b0; e_err[d] = 1'b0; e_ren[d] = 1'b0;
        e_rrst[d] = 1'b0; e_hwen[d] = 1'b0; e_mmst[d] = 1'b0;
        e_phase[d] = 0; e_iaddr[d] = 0; e_haddr[d] = 0;
    endtask

    task automatic model_step(input int d, input bit st, input bit ab, input bit sk,
                              input bit mb, input int ini, input int rn);
        bit ab_now;
        int n, l, w0;
        ab_now = 1'b0;
        e_err[d] = 1'b0;
        if (m_ph[d] == 0) begin
            if (st) begin
                if (rn != 0) begin
                    m_init[d] = ini; m_run[d] = rn; m_skip[d] = sk;
                    m_k[d] = 1; m_ph[d] = 1; e_iaddr[d] = 0; e_haddr[d] = 0;
                end else begin
                    e_err[d] = 1'b1;
                end
            end
        end else if (ab) begin
            m_ph[d] = 0; m_k[d] = 0; ab_now = 1'b1;
        end else if (m_ph[d] == 7) begin
            m_ph[d] = 0;
        end else if (m_ph[d] == 6) begin
            if (m_mmw[d] >= 1 && !mb) m_ph[d] = 7;
            else m_mmw[d] = m_mmw[d] + 1;
        end else begin
            m_k[d] = m_k[d] + 1;
            m_ph[d] = tl_phase(m_k[d], m_init[d], m_run[d], lat[d], m_skip[d]);
            if (m_ph[d] == 6) m_mmw[d] = 0;
        end
        n  = m_init[d] + m_run[d];
        l  = lat[d];
        w0 = m_init[d] + 3 + l;
        e_busy[d]  = (m_ph[d] != 0);
        e_phase[d] = m_ph[d];
        e_done[d]  = (m_ph[d] == 7);
        e_mmst[d]  = (m_ph[d] == 5);
        e_rrst[d]  = (m_ph[d] == 1) || ab_now;
        if (m_ph[d] == 2 || m_ph[d] == 3) e_iaddr[d] = (m_k[d] - 2) & amask[d];
        e_ren[d]  = (m_ph[d] != 0) && (m_k[d] >= 3) && (m_k[d] <= n + 2);
        e_hwen[d] = (m_ph[d] != 0) && (m_k[d] >= w0) && (m_k[d] <= n + 2 + l);
        if (e_hwen[d]) e_haddr[d] = (m_k[d] - w0) & amask[d];
    endtask

    // Model advance on every active edge, using the inputs the DUT samples
    always @(posedge clk) begin
        if (rst) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, a_start, a_abort, a_skip, a_mmb, int'(a_init), int'(a_run));
            model_step(1, b_start, b_abort, b_skip, b_mmb, int'(b_init), int'(b_run));
        end
    end

    // ---------------- comparison ----------------
    task automatic cmp(input string nm, input int d, input int act, input int exp);
        n_tests = n_tests + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s dut%0d cyc %0d: got %0d expected %0d", nm, d, cyc, act, exp);
        end
    endtask

    task automatic cmp_dut(input int d, input logic bsy, dn, er, rn, rr, hw, ms,
                           input logic [2:0] ph, input logic [15:0] ia, ha);
        cmp("busy", d, int'(bsy), int'(e_busy[d]));
        cmp("done", d, int'(dn), int'(e_done[d]));
        cmp("err", d, int'(er), int'(e_err[d]));
        cmp("phase", d, int'(ph), e_phase[d]);
        cmp("input_addr", d, int'(ia), e_iaddr[d]);
        cmp("reservoir_en", d, int'(rn), int'(e_ren[d]));
        cmp("reservoir_rst", d, int'(rr), int'(e_rrst[d]));
        cmp("history_wen", d, int'(hw), int'(e_hwen[d]));
        cmp("history_addr", d, int'(ha), e_haddr[d]);
        cmp("mm_start", d, int'(ms), int'(e_mmst[d]));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_dut(0, a_busy, a_done, a_err, a_ren, a_rrst, a_hwen, a_mmst, a_phase, a_ia, a_ha);
            cmp_dut(1, b_busy, b_done, b_err, b_ren, b_rrst, b_hwen, b_mmst, b_phase,
                    {12'd0, b_ia}, {12'd0, b_ha});
        end
    end

    // ---------------- observation counters for literal checks ----------------
    int o_ren[2], o_hwen[2], o_done[2], o_mmst[2], o_err[2], o_busy[2];
    int o_init[2], o_drain[2], o_h0[2], o_lasth[2], o_maxh[2], c_w1[2], c_done[2];
    int c_a3, c_mmst;

    task automatic clear_obs();
        for (int d = 0; d < 2; d++) begin
            o_ren[d] = 0; o_hwen[d] = 0; o_done[d] = 0; o_mmst[d] = 0; o_err[d] = 0;
            o_busy[d] = 0; o_init[d] = 0; o_drain[d] = 0; o_h0[d] = 0; o_lasth[d] = -1;
            o_maxh[d] = -1; c_w1[d] = -1; c_done[d] = -1;
        end
        c_a3 = -1; c_mmst = -1;
    endtask

    task automatic obs(input int d, input logic bsy, dn, er, rn, hw, ms,
                       input logic [2:0] ph, input logic [15:0] ia, ha);
        if (rn) o_ren[d] = o_ren[d] + 1;
        if (dn) begin o_done[d] = o_done[d] + 1; c_done[d] = cyc; end
        if (ms) begin o_mmst[d] = o_mmst[d] + 1; if (d == 0) c_mmst = cyc; end
        if (er) o_err[d] = o_err[d] + 1;
        if (bsy) o_busy[d] = o_busy[d] + 1;
        if (ph == 3'd2) o_init[d] = o_init[d] + 1;
        if (ph == 3'd4) o_drain[d] = o_drain[d] + 1;
        if (d == 0 && ph == 3'd3 && ia == 16'd3 && c_a3 < 0) c_a3 = cyc;
        if (hw) begin
            o_hwen[d] = o_hwen[d] + 1;
            o_lasth[d] = int'(ha);
            if (int'(ha) > o_maxh[d]) o_maxh[d] = int'(ha);
            if (ha == 16'd0) o_h0[d] = o_h0[d] + 1;
            if (c_w1[d] < 0) c_w1[d] = cyc;
        end
    endtask

    always @(negedge clk) begin
        obs(0, a_busy, a_done, a_err, a_ren, a_hwen, a_mmst, a_phase, a_ia, a_ha);
        obs(1, b_busy, b_done, b_err, b_ren, b_hwen, b_mmst, b_phase, {12'd0, b_ia}, {12'd0, b_ha});
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_done(input int d, input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            tick(1);
            if ((d == 0) ? a_done : b_done) seen = 1'b1;
        end
        cmp("done_timeout", d, int'(seen), 1);
    endtask

    int c0;
    bit hit;

    initial begin
        rst = 1'b1;
        a_start = 1'b0; a_abort = 1'b0; a_skip = 1'b0; a_mmb = 1'b0; a_init = 32'd0; a_run = 16'd0;
        b_start = 1'b0; b_abort = 1'b0; b_skip = 1'b0; b_mmb = 1'b0; b_init = 8'd0; b_run = 4'd0;
        clear_obs();
        tick(1);
        chk_en = 1'b1;
        tick(1);
        cmp("reset_phase", 0, int'(a_phase), 0);
        cmp("reset_busy", 0, int'(a_busy), 0);
        rst = 1'b0;
        tick(2);

        // 1: init=3 run=5 skip_mm=1; config changed after start must not matter
        clear_obs();
        a_init = 32'd3; a_run = 16'd5; a_skip = 1'b1; a_start = 1'b1;
        c0 = cyc;
        tick(1);
        a_start = 1'b0; a_init = 32'd7; a_run = 16'd9; a_skip = 1'b0;
        wait_done(0, 60);
        tick(2);
        cmp("t1_ren_count", 0, o_ren[0], 8);
        cmp("t1_hwen_count", 0, o_hwen[0], 5);
        cmp("t1_last_haddr", 0, o_lasth[0], 4);
        cmp("t1_first_write_lag", 0, c_w1[0] - c_a3, 2);
        cmp("t1_done_count", 0, o_done[0], 1);
        cmp("t1_run_length", 0, c_done[0] - c0, 12);

        // 2: init=0 run=4 with matrix multiply, mm_busy high for 10 cycles
        clear_obs();
        a_init = 32'd0; a_run = 16'd4; a_skip = 1'b0; a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin tick(1); if (a_mmst) hit = 1'b1; end
        cmp("t2_mm_start_seen", 0, int'(hit), 1);
        tick(1);
        a_mmb = 1'b1;
        tick(10);
        a_mmb = 1'b0;
        wait_done(0, 20);
        tick(2);
        cmp("t2_init_cycles", 0, o_init[0], 0);
        cmp("t2_mm_start_count", 0, o_mmst[0], 1);
        cmp("t2_done_lag", 0, c_done[0] - c_mmst, 12);
        cmp("t2_hwen_count", 0, o_hwen[0], 4);

        // 3: rejected start, then a start while busy is ignored
        clear_obs();
        a_init = 32'd2; a_run = 16'd0; a_skip = 1'b1; a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
        tick(3);
        cmp("t3_err_count", 0, o_err[0], 1);
        cmp("t3_busy_cycles", 0, o_busy[0], 0);
        cmp("t3_ren_count", 0, o_ren[0], 0);
        clear_obs();
        a_run = 16'd3; a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
        tick(2);
        a_run = 16'd0; a_init = 32'd9; a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
        wait_done(0, 40);
        tick(2);
        cmp("t3_busy_start_err", 0, o_err[0], 0);
        cmp("t3_busy_ren_count", 0, o_ren[0], 5);
        cmp("t3_busy_done_count", 0, o_done[0], 1);

        // 4: abort during RUN at run step 2, then a clean restart
        clear_obs();
        a_init = 32'd2; a_run = 16'd6; a_skip = 1'b1; a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick(1);
            if (a_phase == 3'd3 && a_ia == 16'd4) hit = 1'b1;
        end
        cmp("t4_reached_step", 0, int'(hit), 1);
        a_abort = 1'b1;
        tick(1);
        a_abort = 1'b0;
        cmp("t4_abort_phase", 0, int'(a_phase), 0);
        cmp("t4_abort_rrst", 0, int'(a_rrst), 1);
        clear_obs();
        tick(10);
        cmp("t4_post_hwen", 0, o_hwen[0], 0);
        cmp("t4_post_ren", 0, o_ren[0], 0);
        cmp("t4_post_done", 0, o_done[0], 0);
        a_init = 32'd1; a_run = 16'd2; a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
        wait_done(0, 30);
        tick(2);
        cmp("t4_restart_hwen", 0, o_hwen[0], 2);
        cmp("t4_restart_done", 0, o_done[0], 1);

        // 5: reset in MM_WAIT
        clear_obs();
        a_init = 32'd1; a_run = 16'd2; a_skip = 1'b0; a_mmb = 1'b1; a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin tick(1); if (a_phase == 3'd6) hit = 1'b1; end
        cmp("t5_reached_wait", 0, int'(hit), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0; a_mmb = 1'b0;
        cmp("t5_phase", 0, int'(a_phase), 0);
        cmp("t5_busy", 0, int'(a_busy), 0);
        cmp("t5_haddr", 0, int'(a_ha), 0);
        cmp("t5_iaddr", 0, int'(a_ia), 0);
        cmp("t5_rrst", 0, int'(a_rrst), 0);
        clear_obs();
        tick(10);
        cmp("t5_no_mm_start", 0, o_mmst[0], 0);
        cmp("t5_no_done", 0, o_done[0], 0);

        // 6: latency 3, full 4-bit run count on instance B
        clear_obs();
        b_init = 8'd1; b_run = 4'd15; b_skip = 1'b1; b_start = 1'b1;
        c0 = cyc;
        tick(1);
        b_start = 1'b0;
        wait_done(1, 60);
        tick(2);
        cmp("t6_hwen_count", 1, o_hwen[1], 15);
        cmp("t6_last_haddr", 1, o_lasth[1], 14);
        cmp("t6_max_haddr", 1, o_maxh[1], 14);
        cmp("t6_no_wrap", 1, o_h0[1], 1);
        cmp("t6_drain_cycles", 1, o_drain[1], 4);
        cmp("t6_run_length", 1, c_done[1] - c0, 22);

        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
